// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: shift-add multiply sequencer and HI/LO pair for MULTU/MADDU/MFHI/MFLO.
// Optional build macro MDU_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module mdu_hilo_ctrl #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_multu,
    input  logic             start_maddu,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rd_hi_req,
    input  logic             rd_lo_req,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_r;
    logic             busy_r;
    logic             done_r;
    logic             op_madd_r;
    logic [PW-1:0]    mcand_r;
    logic [PW-1:0]    acc_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [CW-1:0]    count_r;

    logic [PW-1:0]    acc_next_s;
    logic [PW-1:0]    commit_s;
    logic [WIDTH-1:0] mplier_next_s;
    logic [CW-1:0]    count_next_s;
    logic             last_s;
    logic             start_s;

    // Sum of the multiplicand copies selected by the low BPC multiplier bits
    function automatic logic [PW-1:0] partial_product(input logic [PW-1:0] a,
                                                      input logic [BPC-1:0] b);
        logic [PW-1:0] sum;
        sum = {PW{1'b0}};
        for (int i = 0; i < BPC; i++) begin
            if (b[i]) sum = sum + (a << i);
            else      sum = sum;
        end
        return sum;
    endfunction

    // One RUN step of the datapath and the value HI/LO takes at commit
    always_comb begin
        acc_next_s    = acc_r + partial_product(mcand_r, mplier_r[BPC-1:0]);
        mplier_next_s = mplier_r >> BPC;
        count_next_s  = count_r - CW'(1'b1);
`ifdef MDU_EARLY_TERM_EN
        last_s = (count_next_s == {CW{1'b0}}) || (mplier_next_s == {WIDTH{1'b0}});
`else
        last_s = (count_next_s == {CW{1'b0}});
`endif
        if (op_madd_r) commit_s = {hi_r, lo_r} + acc_r;
        else           commit_s = acc_r;
    end

    assign start_s = start_multu | start_maddu;

    // Sequencer: IDLE latches operands, RUN shifts and accumulates, WB commits HI/LO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            op_madd_r <= 1'b0;
            mcand_r   <= {PW{1'b0}};
            acc_r     <= {PW{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (!flush && start_s) begin
                        mcand_r   <= {{WIDTH{1'b0}}, rs_val};
                        mplier_r  <= rt_val;
                        op_madd_r <= start_maddu;
                        acc_r     <= {PW{1'b0}};
                        count_r   <= CW'(STEPS);
                        state_r   <= S_RUN;
                        busy_r    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        acc_r   <= {PW{1'b0}};
                        count_r <= {CW{1'b0}};
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= mcand_r << BPC;
                        mplier_r <= mplier_next_s;
                        count_r  <= count_next_s;
                        if (last_s) state_r <= S_WB;
                    end
                end
                // flush is deliberately not honoured here: the commit is architectural
                S_WB: begin
                    {hi_r, lo_r} <= commit_s;
                    acc_r        <= {PW{1'b0}};
                    count_r      <= {CW{1'b0}};
                    done_r       <= 1'b1;
                    state_r      <= S_IDLE;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stall   = busy_r & (rd_hi_req | rd_lo_req | start_s);
    assign busy    = busy_r;
    assign done    = done_r;
    assign hi      = hi_r;
    assign lo      = lo_r;
    assign rd_data = rd_hi_req ? hi_r : lo_r;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Scoreboard bench for mdu_hilo_ctrl: expected HI/LO and latency are queued at issue,
// a negedge monitor pops them on done and checks busy/stall/rd_data every cycle.
module tb_mdu_hilo_ctrl;
    localparam int W   = 32;
    localparam int BPC = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_multu = 1'b0, start_maddu = 1'b0;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic         rd_hi_req = 1'b0, rd_lo_req = 1'b0, flush = 1'b0;
    logic         stall, busy, done;
    logic [W-1:0] rd_data, hi, lo;

    mdu_hilo_ctrl #(.WIDTH(W), .BPC(BPC)) dut (
        .clk(clk), .rst(rst), .start_multu(start_multu), .start_maddu(start_maddu),
        .rs_val(rs_val), .rt_val(rt_val), .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .rd_data(rd_data),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        logic [63:0] res;
        int          sedge;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [63:0] arch = 64'd0;
    logic [63:0] pend = 64'd0;
    int          win_beg = 0, win_end = 0;
    int          vec = 0, errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vec++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Edges from start to HI/LO update
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MDU_EARLY_TERM_EN
        int msb;
        msb = 0;
        for (int i = 0; i < W; i++) if (b[i]) msb = i + 1;
        if (msb == 0) return 2;
        return (msb + BPC - 1) / BPC + 1;
`else
        return W / BPC + 1;
`endif
    endfunction

    // Monitor
    always @(negedge clk) begin
        logic exp_busy;
        if (done) begin
            if (sbq.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL unexpected_done: got done=1 expected no commit (t=%0t)", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_latency", 64'(cnt - mon_e.sedge), 64'(mon_e.lat));
                arch = mon_e.res;
            end
        end
        exp_busy = (cnt >= win_beg) && (cnt < win_end);
        chk("hi", 64'(hi), 64'(arch[63:32]));
        chk("lo", 64'(lo), 64'(arch[31:0]));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("stall", 64'(stall),
            64'(exp_busy & (rd_hi_req | rd_lo_req | start_multu | start_maddu)));
        chk("rd_data", 64'(rd_data), rd_hi_req ? 64'(arch[63:32]) : 64'(arch[31:0]));
    end

    // Hold the start until stall drops, queue the expected result, optionally flush f edges later
    task automatic issue(input bit madd, input bit multu, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int f);
        exp_t        e;
        logic [63:0] prod;
        int          guard;
        @(posedge clk); #1;
        start_maddu = madd;
        start_multu = multu;
        rs_val      = a;
        rt_val      = b;
        guard       = 0;
        @(negedge clk);
        while (stall && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (stall) begin
            vec++;
            errs++;
            $display("FAIL issue_timeout: stall still 1 after %0d cycles, required 0", guard);
        end else begin
            prod    = {32'd0, a} * {32'd0, b};
            e.sedge = cnt + 1;
            e.lat   = exp_lat(b);
            e.res   = madd ? pend + prod : prod;
            win_beg = e.sedge;
            if (f > 0 && f < e.lat) begin
                win_end = e.sedge + f;
            end else begin
                win_end = e.sedge + e.lat;
                sbq.push_back(e);
                pend = e.res;
            end
        end
        @(posedge clk); #1;
        start_maddu = 1'b0;
        start_multu = 1'b0;
        if (f > 0) begin
            repeat (f - 1) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((sbq.size() != 0 || busy) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (sbq.size() != 0 || busy) begin
            vec++;
            errs++;
            $display("FAIL drain_timeout: %0d results pending, busy=%0b, required 0/0", sbq.size(), busy);
        end
    endtask

    task automatic reset_mid();
        @(posedge clk); #2;
        rst     = 1'b0;
        arch    = 64'd0;
        pend    = 64'd0;
        sbq.delete();
        win_beg = 0;
        win_end = 0;
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
    endtask

    initial begin
        int guard;
        int op;
        logic [W-1:0] a, b;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        drain();
        chk("max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("max_lo", 64'(lo), 64'h0000_0000_0000_0001);

        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        issue(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 0);
        drain();
        chk("carry_hi", 64'(hi), 64'h0000_0000_0000_0001);
        chk("carry_lo", 64'(lo), 64'h0000_0000_0000_0000);

        issue(1'b0, 1'b1, 32'd7, 32'd6, 0);
        @(posedge clk); #1 rd_lo_req = 1'b1;
        guard = 0;
        @(negedge clk);
        while (stall && guard < 60) begin
            guard++;
            @(negedge clk);
        end
        chk("mflo_done", 64'(done), 64'd1);
        chk("mflo_data", 64'(rd_data), 64'd42);
        @(posedge clk); #1 rd_lo_req = 1'b0;

        issue(1'b0, 1'b1, 32'h8000_0000, 32'h0000_000A, 0);
        issue(1'b1, 1'b0, 32'd9, 32'd1, 0);
        drain();
        issue(1'b0, 1'b1, $urandom, $urandom, 10);
        repeat (40) @(negedge clk);
        chk("flush_hi", 64'(hi), 64'd5);
        chk("flush_lo", 64'(lo), 64'd9);

        issue(1'b1, 1'b1, 32'd3, 32'd4, 0);
        drain();

        @(posedge clk); #1;
        start_multu = 1'b1;
        flush       = 1'b1;
        rs_val      = 32'd11;
        rt_val      = 32'd13;
        @(posedge clk); #1;
        start_multu = 1'b0;
        flush       = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_flush_busy", 64'(busy), 64'd0);

        issue(1'b0, 1'b1, $urandom, $urandom, W / BPC + 1);
        drain();

        issue(1'b0, 1'b1, 32'd123, 32'd456, 0);
        repeat (10) @(posedge clk);
        reset_mid();
        issue(1'b0, 1'b1, 32'd3, 32'd2, 0);
        drain();
        chk("post_rst_lo", 64'(lo), 64'd6);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'hFFFF_FFFF;
                1:       b = $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            rd_hi_req = 1'($urandom_range(0, 1));
            rd_lo_req = 1'($urandom_range(0, 1));
            issue(op != 0, op != 1, a, b,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        rd_hi_req = 1'b0;
        rd_lo_req = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

endmodule
